// File: rtl/lc3_decode_stage.sv
// LC3 decode pipeline stage: registers the fetched instruction and its PC+1,
// and decodes the opcode into execute, writeback and memory control words.
//
// Ports:
//   clock         stage clock, all state changes on the rising edge
//   reset         synchronous active-low reset
//   enable_decode capture strobe from fetch
//   npc_in        PC+1 of the instruction on instr_dout
//   instr_dout    instruction word from instruction memory
//   IR            registered instruction
//   npc_out       registered npc_in
//   E_control     {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
//   W_control     writeback select: 00 ALU, 01 memory, 10 PC
//   Mem_control   1 = indirect access (LDI/STI)
//   decode_valid  high for the cycle after a capture
//   illegal_op    captured opcode is not supported
module lc3_decode_stage #(
    parameter int DATA_W       = 16,
    parameter bit ILLEGAL_ZERO = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable_decode,
    input  logic [DATA_W-1:0] npc_in,
    input  logic [DATA_W-1:0] instr_dout,
    output logic [DATA_W-1:0] IR,
    output logic [DATA_W-1:0] npc_out,
    output logic [5:0]        E_control,
    output logic [1:0]        W_control,
    output logic              Mem_control,
    output logic              decode_valid,
    output logic              illegal_op
);

    logic [3:0] opcode;
    logic       imm_mode;
    logic [5:0] e_next;
    logic [1:0] w_next;
    logic       m_next;
    logic       legal;

    assign opcode   = instr_dout[15:12];
    assign imm_mode = instr_dout[5];

    always_comb begin
        e_next = 6'b000000;
        w_next = 2'b00;
        m_next = 1'b0;
        legal  = 1'b1;
        case (opcode)
            4'b0001: e_next = imm_mode ? 6'b000000 : 6'b000001;
            4'b0101: e_next = imm_mode ? 6'b010000 : 6'b010001;
            4'b1001: e_next = 6'b100000;
            4'b0000: e_next = 6'b000110;
            4'b1100: e_next = 6'b001100;
            4'b0010: begin
                e_next = 6'b000110;
                w_next = 2'b01;
            end
            4'b0110: begin
                e_next = 6'b001000;
                w_next = 2'b01;
            end
            4'b1010: begin
                e_next = 6'b000110;
                w_next = 2'b01;
                m_next = 1'b1;
            end
            4'b1110: begin
                e_next = 6'b000110;
                w_next = 2'b10;
            end
            4'b0011: e_next = 6'b000110;
            4'b0111: e_next = 6'b001000;
            4'b1011: begin
                e_next = 6'b000110;
                m_next = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            IR           <= '0;
            npc_out      <= '0;
            E_control    <= '0;
            W_control    <= '0;
            Mem_control  <= 1'b0;
            decode_valid <= 1'b0;
            illegal_op   <= 1'b0;
        end else if (enable_decode) begin
            IR           <= instr_dout;
            npc_out      <= npc_in;
            decode_valid <= 1'b1;
            illegal_op   <= ~legal;
            // Illegal opcodes decode to all-zero words, so writing them
            // clears; with ILLEGAL_ZERO off the old words are kept instead.
            if (legal || ILLEGAL_ZERO) begin
                E_control   <= e_next;
                W_control   <= w_next;
                Mem_control <= m_next;
            end
        end else begin
            decode_valid <= 1'b0;
        end
    end

endmodule

// File: doc/lc3_decode_stage.md
Name: lc3_decode_stage

Overview:
- Registered LC3 instruction-decode pipeline stage.
- Sits directly downstream of the decode_in agent/fetch interface. It consumes npc_in, instr_dout and enable_decode, and produces the IR plus the execute, writeback and memory control words for the execute stage.
- One cycle of latency. Outputs hold while enable_decode is low.

Parameters:
- DATA_W, 16, width of instruction, IR, npc_in and npc_out (LC3 fixed; only 16 is supported).
- ILLEGAL_ZERO, 1, when 1, unrecognised opcodes clear all control words; when 0, they hold the previous control words.

Ports:
- clock  in  1  stage clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clock edge).
- enable_decode  in  1  capture/decode strobe from upstream.
- npc_in  in  16  PC+1 of the instruction on instr_dout.
- instr_dout  in  16  instruction word from instruction memory.
- IR  out  16  registered instruction.
- npc_out  out  16  registered npc_in.
- E_control  out  6  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}.
- W_control  out  2  writeback select: 00 ALU, 01 memory, 10 PC (LEA).
- Mem_control  out  1  1 = indirect access (LDI/STI).
- decode_valid  out  1  1 for exactly the cycle after a capture.
- illegal_op  out  1  registered flag: the captured opcode is not supported.

Behaviour:
- Reset (reset==0 at a rising edge):
  - IR, npc_out, E_control, W_control, Mem_control, decode_valid and illegal_op all go to 0.
  - Reset has priority over enable_decode.
  - Reset mid-stream discards the captured instruction; the first capture after release decodes normally.
- Capture (reset==1, enable_decode==1 at a rising edge):
  - IR <= instr_dout and npc_out <= npc_in.
  - Control words are decoded from instr_dout[15:12] and registered in the same edge.
  - decode_valid <= 1.
  - Latency is one clock, from input sample to output.
- Hold (reset==1, enable_decode==0):
  - All data and control outputs keep their values.
  - decode_valid <= 0.
- Back-to-back enables: every cycle captures a new instruction. decode_valid stays high and there are no bubbles.
- Decode table (opcode: E_control, W_control, Mem_control):
  - ADD 0001: IR[5]=1 -> 000000, else 000001; W 00; M 0.
  - AND 0101: IR[5]=1 -> 010000, else 010001; W 00; M 0.
  - NOT 1001: 100000; W 00; M 0.
  - BR 0000: 000110; W 00; M 0.
  - JMP 1100: 001100; W 00; M 0.
  - LD 0010: 000110; W 01; M 0.
  - LDR 0110: 001000; W 01; M 0.
  - LDI 1010: 000110; W 01; M 1.
  - LEA 1110: 000110; W 10; M 0.
  - ST 0011: 000110; W 00; M 0.
  - STR 0111: 001000; W 00; M 0.
  - STI 1011: 000110; W 00; M 1.
- Field encodings:
  - pcselect1: 00 offset11, 01 offset9, 10 offset6, 11 zero.
  - pcselect2: 1 = npc, 0 = base register.
  - op2select: 1 = register operand, 0 = imm5.
- Illegal opcodes (0100, 1000, 1101, 1111) on a capture:
  - IR and npc_out still update; illegal_op <= 1.
  - ILLEGAL_ZERO=1: E_control, W_control and Mem_control go to 0.
  - ILLEGAL_ZERO=0: E_control, W_control and Mem_control hold their previous values.
- illegal_op is updated only on a capture; it holds while enable_decode is 0.
- npc_out is a pure register copy; no arithmetic is performed; the 16-bit width is preserved.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: hold reset=0 for 2 cycles with enable_decode=1 and instr_dout=16'h1042 -> all outputs 0, decode_valid=0. Release reset -> next capture decodes normally.
- ADD register/immediate: instr 16'h1042 (ADD R0,R1,R2), npc 16'h3001 -> next cycle IR=16'h1042, npc_out=16'h3001, E=000001, W=00, M=0, decode_valid=1. Then instr 16'h1063 (ADD imm) -> E=000000.
- Load/store family: LDI 16'hA205 -> E=000110, W=01, M=1. LDR 16'h6285 -> E=001000, W=01, M=0. LEA 16'hE3FF -> W=10. STI 16'hB001 -> M=1, W=00.
- Hold: capture 16'h5020 (AND imm), then enable_decode=0 for 3 cycles with instr_dout toggling random -> IR=16'h5020, E=010000 unchanged, decode_valid=0 for those cycles.
- Illegal opcode: after JMP 16'hC1C0 (E=001100), capture 16'hD000 -> illegal_op=1, IR=16'hD000. E/W/M=0 when ILLEGAL_ZERO=1; E=001100 held when ILLEGAL_ZERO=0. The next legal capture clears illegal_op.
- Streaming and reset mid-stream: 8 consecutive enables with distinct opcodes -> outputs track the inputs with 1-cycle lag and decode_valid stays high. Assert reset on the 5th cycle -> all outputs 0 on the following edge.
